// File: rtl/xbus_glb_scheduler.sv
// GLB -> X-bus sequencer: fetches `length` GLB words, stamps each with a column TAG and ends every job with flush/done.
// Optional back-pressure counter on stall_cycles_o is built only when XBUS_SCHED_PERF_EN is defined.
module xbus_glb_scheduler #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_COL    = 4,
    parameter int GLB_DEPTH  = 1024,
    localparam int AW = $clog2(GLB_DEPTH),
    localparam int TW = (NUM_COL > 1) ? $clog2(NUM_COL) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic                  abort_i,
    input  logic [AW-1:0]         base_addr_i,
    input  logic [15:0]           length_i,
    input  logic [7:0]            words_per_col_i,
    output logic                  glb_en_o,
    output logic [AW-1:0]         glb_addr_o,
    input  logic [DATA_WIDTH-1:0] glb_rd_data_i,
    output logic [DATA_WIDTH-1:0] bus_data_o,
    output logic [TW-1:0]         bus_tag_o,
    output logic                  bus_valid_o,
    input  logic                  bus_ready_i,
    output logic                  flush_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [31:0]           stall_cycles_o
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_SEND  = 3'd3;
    localparam logic [2:0] S_FLUSH = 3'd4;

    logic [2:0]            state_q, state_d;
    logic [AW-1:0]         addr_q, addr_d;
    logic [15:0]           len_q, len_d;
    logic [15:0]           idx_q, idx_d;
    logic [7:0]            wpc_q, wpc_d;
    logic [7:0]            wc_q, wc_d;
    logic [TW-1:0]         tag_q, tag_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  hs;
    logic                  last;

    assign hs   = (state_q == S_SEND) && bus_ready_i;
    assign last = ({1'b0, idx_q} + 17'd1) == {1'b0, len_q};

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        idx_d   = idx_q;
        wpc_d   = wpc_q;
        wc_d    = wc_q;
        tag_d   = tag_q;
        data_d  = data_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    addr_d  = base_addr_i;
                    len_d   = length_i;
                    wpc_d   = (words_per_col_i == 8'd0) ? 8'd1 : words_per_col_i;
                    idx_d   = '0;
                    wc_d    = '0;
                    tag_d   = '0;
                    state_d = (length_i == 16'd0) ? S_FLUSH : S_FETCH;
                end
            end
            S_FETCH: state_d = abort_i ? S_FLUSH : S_WAIT;
            S_WAIT: begin
                // An aborted read never reaches the bus register.
                if (abort_i) begin
                    state_d = S_FLUSH;
                end else begin
                    data_d  = glb_rd_data_i;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (hs) begin
                    idx_d  = idx_q + 16'd1;
                    addr_d = (addr_q == AW'(GLB_DEPTH - 1)) ? '0 : addr_q + AW'(1);
                    if (({1'b0, wc_q} + 9'd1) >= {1'b0, wpc_q}) begin
                        wc_d  = '0;
                        tag_d = (tag_q == TW'(NUM_COL - 1)) ? '0 : tag_q + TW'(1);
                    end else begin
                        wc_d = wc_q + 8'd1;
                    end
                end
                if (abort_i || (hs && last)) state_d = S_FLUSH;
                else if (hs)                 state_d = S_FETCH;
            end
            S_FLUSH: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            wpc_q   <= '0;
            wc_q    <= '0;
            tag_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            wpc_q   <= wpc_d;
            wc_q    <= wc_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
        end
    end

    assign glb_en_o    = (state_q == S_FETCH);
    assign glb_addr_o  = addr_q;
    assign bus_data_o  = data_q;
    assign bus_tag_o   = tag_q;
    assign bus_valid_o = (state_q == S_SEND);
    assign flush_o     = (state_q == S_FLUSH);
    assign done_o      = (state_q == S_FLUSH);
    assign busy_o      = (state_q != S_IDLE);

`ifdef XBUS_SCHED_PERF_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || (state_q == S_IDLE && start_i)) begin
            stall_q <= '0;
        end else if (state_q == S_SEND && !bus_ready_i && stall_q != 32'hFFFF_FFFF) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cycles_o = stall_q;
`else
    assign stall_cycles_o = 32'd0;
`endif

endmodule

// File: tb/tb_xbus_glb_scheduler.sv
// Randomised + directed bench for xbus_glb_scheduler against a timeline model of each job.
module tb_xbus_glb_scheduler;
  localparam int DW = 16, NC = 4, DEPTH = 1024, AW = 10, TW = 2;

  logic clk = 0, rst = 1, start = 0, abort = 0;
  logic [AW-1:0] base_addr = '0;
  logic [15:0] length = '0;
  logic [7:0] wpc = '0;
  logic glb_en;
  logic [AW-1:0] glb_addr;
  logic [DW-1:0] glb_rd_data = '0;
  logic [DW-1:0] bus_data;
  logic [TW-1:0] bus_tag;
  logic bus_valid, bus_ready = 1;
  logic flush, busy, done;
  logic [31:0] stall_cycles;

  int n_pass = 0, n_total = 0;
  int en_q[$], tg_q[$];
  int rmode = 0, bp_left = 0;

  always #5 clk = ~clk;

  xbus_glb_scheduler #(.DATA_WIDTH(DW), .NUM_COL(NC), .GLB_DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort),
    .base_addr_i(base_addr), .length_i(length), .words_per_col_i(wpc),
    .glb_en_o(glb_en), .glb_addr_o(glb_addr), .glb_rd_data_i(glb_rd_data),
    .bus_data_o(bus_data), .bus_tag_o(bus_tag), .bus_valid_o(bus_valid),
    .bus_ready_i(bus_ready), .flush_o(flush), .busy_o(busy), .done_o(done),
    .stall_cycles_o(stall_cycles));

  function automatic logic [DW-1:0] mem_word(int a);
    return DW'((a * 40503 + 7) ^ (a >> 3));
  endfunction

  // GLB: synchronous read, data one cycle after the enable
  always @(posedge clk) if (glb_en) glb_rd_data <= mem_word(int'(glb_addr));

  task automatic check(string name, longint act, longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic check_seq(string name, int got[$], int exp[$]);
    check({name, "_len"}, got.size(), exp.size());
    foreach (exp[i]) if (i < got.size()) check(name, got[i], exp[i]);
  endtask

  // Model: a job is a word count plus cycles elapsed since the current word's fetch.
  bit m_active = 0, m_flush = 0, m_rst = 0;
  int m_t = 0, m_n = 0, m_len = 0, m_base = 0, m_wpc = 1;
  longint m_stall = 0;

  always @(posedge clk) begin
    bit hs;
    hs = 0;
    if (rst) begin
      m_active = 0; m_flush = 0; m_rst = 1; m_stall = 0;
    end else if (m_flush) begin
      m_flush = 0;
    end else if (!m_active) begin
      if (start) begin
        m_rst = 0; m_base = int'(base_addr); m_len = int'(length);
        m_wpc = (wpc == 0) ? 1 : int'(wpc); m_n = 0; m_stall = 0;
        if (length == 0) m_flush = 1;
        else begin m_active = 1; m_t = 0; end
      end
    end else begin
      hs = (m_t >= 2) && bus_ready;
      if (m_t >= 2 && !bus_ready && m_stall < 64'hFFFF_FFFF) m_stall++;
      if (hs) m_n++;
      if (abort || (hs && m_n == m_len)) begin m_active = 0; m_flush = 1; end
      else if (hs) m_t = 0;
      else if (m_t < 2) m_t++;
    end
  end

  always @(negedge clk) begin
    int a;
    a = (m_base + m_n) % DEPTH;
    check("glb_en", glb_en, m_active && m_t == 0);
    if (m_active && m_t == 0) check("glb_addr", glb_addr, a);
    check("bus_valid", bus_valid, m_active && m_t >= 2);
    if (m_active && m_t >= 2) begin
      check("bus_data", bus_data, mem_word(a));
      check("bus_tag", bus_tag, (m_n / m_wpc) % NC);
    end
    check("flush", flush, m_flush);
    check("done", done, m_flush);
    check("busy", busy, m_active || m_flush);
    if (m_rst) begin
      check("rst_glb_addr", glb_addr, 0);
      check("rst_bus_data", bus_data, 0);
      check("rst_bus_tag", bus_tag, 0);
    end
`ifdef XBUS_SCHED_PERF_EN
    check("stall_cycles", stall_cycles, m_stall);
`else
    check("stall_cycles", stall_cycles, 0);
`endif
    if (glb_en) en_q.push_back(int'(glb_addr));
    if (bus_valid && bus_ready) tg_q.push_back(int'(bus_tag));
  end

  initial forever begin
    @(posedge clk); #1;
    case (rmode)
      1: bus_ready = ($urandom % 4) != 0;
      2: if (bus_valid && tg_q.size() == 1 && bp_left > 0) begin bus_ready = 0; bp_left--; end
         else bus_ready = 1;
      default: bus_ready = 1;
    endcase
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start_job(int b, int l, int w);
    base_addr = AW'(b); length = 16'(l); wpc = 8'(w);
    start = 1; tick(); start = 0;
  endtask

  task automatic wait_idle(int budget);
    int c;
    c = 0;
    while (busy && c < budget) begin tick(); c++; end
    check("job_timeout", busy, 0);
    tick();
  endtask

  initial begin
    int exp[$];
    int lat, c;
    tick(); tick(); tick();
    rst = 0; tick();

    // basic job + first-valid latency
    en_q.delete(); tg_q.delete();
    start_job(10, 4, 1);
    lat = 1;
    while (!bus_valid && lat < 10) begin tick(); lat++; end
    check("first_valid_latency", lat, 3);
    wait_idle(100);
    exp = '{10, 11, 12, 13}; check_seq("basic_addr", en_q, exp);
    exp = '{0, 1, 2, 3};     check_seq("basic_tag", tg_q, exp);

    // address wrap
    en_q.delete(); tg_q.delete();
    start_job(1022, 4, 1); wait_idle(100);
    exp = '{1022, 1023, 0, 1}; check_seq("wrap_addr", en_q, exp);

    // TAG grouping
    en_q.delete(); tg_q.delete();
    start_job(100, 10, 2); wait_idle(200);
    exp = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0}; check_seq("group_tag", tg_q, exp);

    // back-pressure on word 2
    en_q.delete(); tg_q.delete();
    rmode = 2; bp_left = 5;
    start_job(200, 4, 1); wait_idle(200);
    rmode = 0;
    check("bp_glb_reads", en_q.size(), 4);
`ifdef XBUS_SCHED_PERF_EN
    check("bp_stall_cycles", stall_cycles, 5);
`endif

    // length 0
    en_q.delete(); tg_q.delete();
    start_job(7, 0, 1);
    check("len0_done", done, 1);
    wait_idle(10);
    check("len0_glb_reads", en_q.size(), 0);

    // start while busy is ignored
    en_q.delete(); tg_q.delete();
    start_job(20, 5, 1); tick(); tick();
    length = 16'd9; start = 1; tick(); start = 0;
    wait_idle(200);
    check("busy_start_words", tg_q.size(), 5);

    // abort during WAIT of first word
    en_q.delete(); tg_q.delete();
    start_job(5, 4, 1); tick();
    abort = 1; tick(); abort = 0;
    check("abort_flush", flush, 1);
    wait_idle(10);
    check("abort_words", tg_q.size(), 0);
    check("abort_reads", en_q.size(), 1);

    // reset during SEND of second word, then a fresh job
    en_q.delete(); tg_q.delete();
    start_job(300, 4, 1);
    c = 0;
    while (!(bus_valid && tg_q.size() == 1) && c < 50) begin tick(); c++; end
    check("rst_reach_send", bus_valid, 1);
    rst = 1; tick(); rst = 0;
    check("rst_busy", busy, 0);
    tick();
    en_q.delete(); tg_q.delete();
    start_job(50, 3, 1); wait_idle(100);
    exp = '{0, 1, 2}; check_seq("post_rst_tag", tg_q, exp);

    // randomised jobs with random back-pressure, aborts and stray starts
    rmode = 1;
    for (int j = 0; j < 30; j++) begin
      start_job($urandom_range(0, 1023), $urandom_range(0, 12), $urandom_range(0, 3));
      c = 0;
      while (busy && c < 300) begin
        abort = ($urandom % 25) == 0;
        start = ($urandom % 8) == 0;
        length = 16'($urandom_range(0, 20));
        tick(); c++;
      end
      abort = 0; start = 0;
      check("rand_job_end", busy, 0);
      tick();
    end
    rmode = 0;
    tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_total);
    $fatal(1);
  end
endmodule
